// File: rtl/int24_to_float.sv
// int24_to_float: 24-bit two's complement sample to IEEE-754 single.
// Define INT24_TO_FLOAT_SCALE_EN to scale the result by 2^-23.
`timescale 1ns/1ps
module int24_to_float (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic [23:0] i_DATA,
    input  logic        i_DATA_VALID,
    output logic        o_DATA_READY,
    output logic [31:0] o_F_DATA,
    output logic        o_F_DATA_VALID,
    input  logic        i_F_READY
);

`ifdef INT24_TO_FLOAT_SCALE_EN
    localparam logic [7:0] EXP_BASE = 8'd127;
`else
    localparam logic [7:0] EXP_BASE = 8'd150;
`endif

    localparam logic [5:0] MAX_SHIFTS = 6'd23;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVERT   = 3'd1,
        NORMALIZE = 3'd2,
        PACK      = 3'd3,
        OUTPUT    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] data_q, data_d;
    logic        sign_q, sign_d;
    logic [23:0] mant_q, mant_d;
    logic [7:0]  exp_q, exp_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        zero_q, zero_d;
    logic        ready_q, ready_d;
    logic [31:0] f_q, f_d;
    logic        fvalid_q, fvalid_d;
    logic [23:0] abs_x;

    // Magnitude of the captured sample; 0x800000 maps onto itself.
    always_comb begin
        abs_x = data_q[23] ? (~data_q + 24'd1) : data_q;
    end

    // Next-state and datapath for the conversion sequence.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sign_d   = sign_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        ready_d  = ready_q;
        f_d      = f_q;
        fvalid_d = fvalid_q;
        case (state_q)
            IDLE: begin
                if (ready_q && i_DATA_VALID) begin
                    data_d  = i_DATA;
                    ready_d = 1'b0;
                    state_d = CONVERT;
                end else begin
                    ready_d = 1'b1;
                end
            end
            CONVERT: begin
                sign_d  = data_q[23];
                mant_d  = abs_x;
                exp_d   = EXP_BASE;
                cnt_d   = MAX_SHIFTS;
                zero_d  = (data_q == 24'd0);
                state_d = (data_q == 24'd0) ? PACK : NORMALIZE;
            end
            NORMALIZE: begin
                if (mant_q[23] || (cnt_q == 6'd0)) begin
                    state_d = PACK;
                end else begin
                    mant_d = {mant_q[22:0], 1'b0};
                    exp_d  = exp_q - 8'd1;
                    cnt_d  = cnt_q - 6'd1;
                end
            end
            PACK: begin
                f_d      = zero_q ? 32'h0 : {sign_q, exp_q, mant_q[22:0]};
                fvalid_d = 1'b1;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                if (i_F_READY) begin
                    fvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                ready_d  = 1'b0;
                fvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q  <= IDLE;
            data_q   <= 24'd0;
            sign_q   <= 1'b0;
            mant_q   <= 24'd0;
            exp_q    <= 8'd0;
            cnt_q    <= 6'd0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b0;
            f_q      <= 32'h0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sign_q   <= sign_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            ready_q  <= ready_d;
            f_q      <= f_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign o_DATA_READY   = ready_q;
    assign o_F_DATA       = f_q;
    assign o_F_DATA_VALID = fvalid_q;

endmodule

// File: tb/tb_int24_to_float.sv
// tb_int24_to_float: directed table, hold, reset and random
// scoreboard checks of the integer-to-float converter.
`timescale 1ns/1ps
module tb_int24_to_float;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] i_data = 24'd0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] o_f;
    logic        o_fvalid;
    logic        f_ready = 1'b1;

    int n_total = 0;
    int n_pass = 0;

    typedef struct {
        logic [23:0] data;
        logic [31:0] f;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    int24_to_float dut (
        .i_CLK(clk),
        .i_RSTN(rstn),
        .i_DATA(i_data),
        .i_DATA_VALID(i_valid),
        .o_DATA_READY(o_ready),
        .o_F_DATA(o_f),
        .o_F_DATA_VALID(o_fvalid),
        .i_F_READY(f_ready)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Reference: value as a real, re-encoded from the double's fields.
    function automatic logic [31:0] ref_f(input logic [23:0] d);
        int          v;
        real         r;
        logic [63:0] b;
        logic [10:0] e;
        v = int'($signed(d));
        if (v == 0) return 32'h0;
        r = v;
`ifdef INT24_TO_FLOAT_SCALE_EN
        r = r / 8388608.0;
`endif
        b = $realtobits(r);
        e = b[62:52] - 11'd1023 + 11'd127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic int ref_lat(input logic [23:0] d);
        int a;
        int k;
        a = int'($signed(d));
        if (a < 0) a = -a;
        if (a == 0) return 2;
        k = 0;
        while (a < (1 << (23 - k))) k++;
        return k + 3;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic convert(input logic [23:0] d, output logic [31:0] f,
                           output int lat);
        wait_ready();
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_data  = ~d;
        lat = 0;
        f = 32'hxxxxxxxx;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_fvalid) break;
        end
        if (o_fvalid) f = o_f;
        else lat = 99;
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] want;
        int          lat;
        int          sent;
        int          recv;
        int          cyc;
        bit          seen;
        logic [23:0] d;

`ifdef INT24_TO_FLOAT_SCALE_EN
        vecs.push_back('{24'h400000, 32'h3F000000, 4});
        vecs.push_back('{24'hFFFFFF, 32'hB4000000, 26});
        vecs.push_back('{24'h800000, 32'hBF800000, 3});
        vecs.push_back('{24'h000000, 32'h00000000, 2});
        vecs.push_back('{24'h000001, 32'h34000000, 26});
`else
        vecs.push_back('{24'h000001, 32'h3F800000, 26});
        vecs.push_back('{24'h7FFFFF, 32'h4AFFFFFE, 4});
        vecs.push_back('{24'h800000, 32'hCB000000, 3});
        vecs.push_back('{24'h000000, 32'h00000000, 2});
        vecs.push_back('{24'hFFFFFF, 32'hBF800000, 26});
        vecs.push_back('{24'h000100, 32'h43800000, 18});
`endif

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_f", o_f, 32'h0);
        chk("rst_fvalid", {31'd0, o_fvalid}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'd0, o_ready}, 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            convert(vecs[i].data, f, lat);
            chk($sformatf("tbl%0d_f", i), f, vecs[i].f);
            chk($sformatf("tbl%0d_lat", i), lat, vecs[i].lat);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_vld_drop", i), {31'd0, o_fvalid}, 32'd0);
            chk($sformatf("tbl%0d_rdy_gap", i), {31'd0, o_ready}, 32'd0);
            chk($sformatf("tbl%0d_retain", i), o_f, vecs[i].f);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_rdy_back", i), {31'd0, o_ready}, 32'd1);
        end

        // Downstream stall while holding a result
        f_ready = 1'b0;
        convert(24'h000100, f, lat);
        want = ref_f(24'h000100);
        chk("hold_first", f, want);
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            i_data  = 24'h123456;
            @(posedge clk); #1;
            chk($sformatf("hold%0d", c),
                {o_f[31:2], o_fvalid, o_ready},
                {want[31:2], 1'b1, 1'b0});
            chk($sformatf("hold%0d_lo", c), {30'd0, o_f[1:0]},
                {30'd0, want[1:0]});
        end
        i_valid = 1'b0;
        f_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", {31'd0, o_fvalid}, 32'd0);
        convert(24'hFFF000, f, lat);
        chk("after_hold_f", f, ref_f(24'hFFF000));
        chk("after_hold_lat", lat, ref_lat(24'hFFF000));

        // Reset during NORMALIZE
        wait_ready();
        i_data  = 24'h000001;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, o_ready}, 32'd0);
        chk("midrst_f", o_f, 32'h0);
        chk("midrst_fvalid", {31'd0, o_fvalid}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready_back", {31'd0, o_ready}, 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (o_fvalid) seen = 1'b1;
        end
        chk("midrst_no_pulse", {31'd0, seen}, 32'd0);
        convert(24'h000003, f, lat);
        chk("midrst_next_f", f, ref_f(24'h000003));
        chk("midrst_next_lat", lat, ref_lat(24'h000003));
        @(posedge clk); #1;

        // Random traffic against the scoreboard
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            f_ready = 1'($urandom_range(0, 1));
            if (o_fvalid && f_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", o_f, 32'hxxxxxxxx);
                end else begin
                    want = exp_q.pop_front();
                    chk($sformatf("rnd%0d", recv), o_f, want);
                end
                recv++;
            end
            if (sent < 100) begin
                i_valid = ($urandom_range(0, 2) != 0);
                d = 24'($urandom);
                i_data = d >> $urandom_range(0, 23);
                if (i_valid && o_ready) begin
                    exp_q.push_back(ref_f(i_data));
                    sent++;
                end
            end else begin
                i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        chk("rnd_count", recv, 100);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/int24_to_float.md
INT24_TO_FLOAT -- requirements
Module: int24_to_float

Interface
REQ-001 SHALL have port i_CLK  input  1  rising-edge clock for all state.
REQ-002 SHALL have port i_RSTN  input  1  reset: asynchronous, active-low; clock i_CLK.
REQ-003 SHALL have port i_DATA  input  24  ADC sample, two's complement.
REQ-004 SHALL have port i_DATA_VALID  input  1  i_DATA valid; transfer when i_DATA_VALID && o_DATA_READY at a clock edge.
REQ-005 SHALL have port o_DATA_READY  output  1  block idle and able to accept a sample.
REQ-006 SHALL have port o_F_DATA  output  32  IEEE-754 single result, feeds filter x input.
REQ-007 SHALL have port o_F_DATA_VALID  output  1  o_F_DATA valid; transfer when o_F_DATA_VALID && i_F_READY at a clock edge.
REQ-008 SHALL have port i_F_READY  input  1  downstream filter ready for x data.

Function
REQ-009 SHALL implement FSM states IDLE, CONVERT, NORMALIZE, PACK, OUTPUT; unknown state -> IDLE.
REQ-010 IDLE: o_DATA_READY=1; on transfer, capture i_DATA, drive o_DATA_READY=0, go CONVERT.
REQ-011 CONVERT (1 cycle): sign=bit23; mant=|x| as 24-bit unsigned (0x800000 -> 0x800000); exp=EXP_BASE; x==0 -> go PACK with zero flag, else go NORMALIZE.
REQ-012 NORMALIZE: mant[23]=1 -> go PACK; else mant<<=1 and exp-=1, stay; 6-bit down-counter bounds shifts to 23.
REQ-013 PACK (1 cycle): o_F_DATA={sign, exp[7:0], mant[22:0]}, or 32'h00000000 when zero flag; o_F_DATA_VALID=1; go OUTPUT.
REQ-014 Conversion SHALL be exact (24 significant bits fit the 24-bit significand); no rounding logic, no -0.0 output.
REQ-015 Latency: o_F_DATA_VALID high k+3 edges after capture edge, k = leading-zero count of |x| (0..23); zero input: 2 edges.
REQ-016 OUTPUT: hold o_F_DATA and o_F_DATA_VALID stable until i_F_READY=1 at an edge; then o_F_DATA_VALID=0, go IDLE.
REQ-017 No sample SHALL be accepted on the same edge as the output transfer; o_DATA_READY returns 1 one edge after it.
REQ-018 i_DATA_VALID outside IDLE SHALL be ignored; i_DATA changes after capture SHALL not affect the result.
REQ-019 o_F_DATA SHALL retain the last result after the transfer until the next PACK.
REQ-020 Back-to-back: i_DATA_VALID held high with i_F_READY high SHALL convert every accepted sample, none lost or duplicated.

Reset
REQ-021 On i_RSTN=0: state IDLE, o_DATA_READY=0, o_F_DATA=32'h0, o_F_DATA_VALID=0, internal sign/mant/exp/counter cleared.
REQ-022 o_DATA_READY SHALL go 1 on the first edge after i_RSTN deasserts.
REQ-023 Reset mid-operation SHALL abandon the sample in progress; no o_F_DATA_VALID pulse for it.

Configuration
REQ-024 Macro INT24_TO_FLOAT_SCALE_EN defined: EXP_BASE=127, output = x * 2^-23 (full scale maps to [-1,1)).
REQ-025 Macro INT24_TO_FLOAT_SCALE_EN undefined: EXP_BASE=150, output = x as an integer-valued float.
REQ-026 Latency and handshakes SHALL be the same in both configurations.

Verification
REQ-027 No macro, i_DATA=24'h000001 -> o_F_DATA=32'h3F800000, valid 26 edges after capture.
REQ-028 No macro, 24'h7FFFFF -> 32'h4AFFFFFE (4 edges); 24'h800000 -> 32'hCB000000 (3 edges); 24'h000000 -> 32'h00000000 (2 edges).
REQ-029 Macro on, 24'h400000 -> 32'h3F000000; 24'hFFFFFF -> 32'hB4000000; 24'h800000 -> 32'hBF800000.
REQ-030 i_F_READY held 0 for 10 cycles in OUTPUT -> o_F_DATA and o_F_DATA_VALID stable, o_DATA_READY=0, new i_DATA_VALID ignored.
REQ-031 i_RSTN pulsed low during NORMALIZE -> all outputs at reset values, no valid pulse, next sample converted correctly.
REQ-032 100 random samples, i_DATA_VALID and i_F_READY randomly toggled -> outputs match a reference model in order, none lost.
